// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the register file and its scoreboard.
package reg_file_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

   // Index of the optional hard-wired zero register.
   localparam int ZERO_IDX = 0;

   // Number of words addressable with addr_w address bits.
   function automatic int depth_of(input int addr_w);
      return 2 ** addr_w;
   endfunction

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count.
// Issue claims a register; writeback retires it. A claim and a retire to the
// same register in one cycle leave it busy (new producer replaces old one).
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int ZERO_R0 = 0
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              claim_en,
   input  logic [ADDR_W-1:0] claim_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DEPTH-1:0] busy_reg;
   logic [DEPTH-1:0] busy_next;
   logic [ADDR_W:0]  cnt_reg;
   logic [ADDR_W:0]  cnt_next;
   logic             claim_eff;
   logic             wr_eff;
   logic             cnt_inc;
   logic             cnt_dec;

   // Qualify claim/retire (register 0 is never tracked when hard-wired) and
   // decide whether the population count moves up, down or stays.
   always_comb begin
      claim_eff = claim_en && !((ZERO_R0 != 0) && (claim_addr == ADDR_W'(ZERO_IDX)));
      wr_eff    = wr_en    && !((ZERO_R0 != 0) && (wr_addr    == ADDR_W'(ZERO_IDX)));
      cnt_inc   = claim_eff && !busy_reg[claim_addr];
      cnt_dec   = wr_eff && busy_reg[wr_addr] &&
                  !(claim_eff && (claim_addr == wr_addr));
   end

   // Per-register next state: claim has priority over retire.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
         assign busy_next[gi] = (claim_eff && (claim_addr == ADDR_W'(gi))) ? 1'b1 :
                                (wr_eff    && (wr_addr    == ADDR_W'(gi))) ? 1'b0 :
                                busy_reg[gi];
      end
   endgenerate

   // Counter update tracks the popcount of busy_reg without an adder tree.
   always_comb begin
      cnt_next = cnt_reg;
      case ({cnt_inc, cnt_dec})
         2'b10:   cnt_next = cnt_reg + (ADDR_W+1)'(1);
         2'b01:   cnt_next = cnt_reg - (ADDR_W+1)'(1);
         default: cnt_next = cnt_reg;
      endcase
   end

   // Busy vector and counter registers; reset discards all pending claims.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         busy_reg <= busy_next;
         cnt_reg  <= cnt_next;
      end
   end

   assign busy1    = busy_reg[rd_addr1];
   assign busy2    = busy_reg[rd_addr2];
   assign busy_cnt = cnt_reg;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-to-read bypass, optional
// hard-wired zero register and a pending-write scoreboard for hazard stalls.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] R1,
   input  logic [ADDR_W-1:0] R2,
   output logic [DATA_W-1:0] RO1,
   output logic [DATA_W-1:0] RO2,
   input  logic              RegW,
   input  logic [ADDR_W-1:0] RD,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              claim_en,
   input  logic [ADDR_W-1:0] claim_addr,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic              wr_eff;
   logic              fwd1;
   logic              fwd2;
   logic              zero1;
   logic              zero2;
   logic              sb_busy1;
   logic              sb_busy2;

   // Decode write qualification, forwarding hits and zero-register hits.
   always_comb begin
      wr_eff = RegW && !((ZERO_R0 != 0) && (RD == ADDR_W'(ZERO_IDX)));
      fwd1   = (BYPASS != 0) && RegW && (RD == R1);
      fwd2   = (BYPASS != 0) && RegW && (RD == R2);
      zero1  = (ZERO_R0 != 0) && (R1 == ADDR_W'(ZERO_IDX));
      zero2  = (ZERO_R0 != 0) && (R2 == ADDR_W'(ZERO_IDX));
   end

   // Storage: reset clears every word, so it has to live in flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (wr_eff) begin
         mem_reg[RD] <= WriteData;
      end
   end

   // Read muxes: the zero register wins over forwarding, forwarding over storage.
   always_comb begin
      RO1 = mem_reg[R1];
      RO2 = mem_reg[R2];
      if (fwd1) RO1 = WriteData;
      if (fwd2) RO2 = WriteData;
      if (zero1) RO1 = '0;
      if (zero2) RO2 = '0;
   end

   // A forwarded operand is not a hazard even if its register is still busy.
   always_comb begin
      busy1 = sb_busy1 && !fwd1;
      busy2 = sb_busy2 && !fwd2;
   end

   reg_scoreboard #(
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .wr_en      (RegW),
      .wr_addr    (RD),
      .rd_addr1   (R1),
      .rd_addr2   (R2),
      .busy1      (sb_busy1),
      .busy2      (sb_busy2),
      .busy_cnt   (busy_cnt)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (default config, and ZERO_R0=1 with
// BYPASS=0) driven by the same stimulus and checked against a small model
// through an expectation queue.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  R1, R2, RD, claim_addr;
   logic        RegW, claim_en;
   logic [15:0] WriteData;

   logic [15:0] ro1_a, ro2_a, ro1_b, ro2_b;
   logic        busy1_a, busy2_a, busy1_b, busy2_b;
   logic [4:0]  cnt_a, cnt_b;

   always #5 clk = ~clk;

   reg_file_sb dut_a (
      .clk(clk), .rst(rst), .R1(R1), .R2(R2), .RO1(ro1_a), .RO2(ro2_a),
      .RegW(RegW), .RD(RD), .WriteData(WriteData),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .busy1(busy1_a), .busy2(busy2_a), .busy_cnt(cnt_a)
   );

   reg_file_sb #(.ZERO_R0(1), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .R1(R1), .R2(R2), .RO1(ro1_b), .RO2(ro2_b),
      .RegW(RegW), .RD(RD), .WriteData(WriteData),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .busy1(busy1_b), .busy2(busy2_b), .busy_cnt(cnt_b)
   );

   typedef struct {
      string       name;
      logic [15:0] a_ro1, a_ro2, b_ro1, b_ro2;
      logic        a_b1, a_b2, b_b1, b_b2;
      logic [4:0]  a_cnt, b_cnt;
   } exp_t;

   exp_t        sbq[$];
   logic [15:0] mem_a [16];
   logic [15:0] mem_b [16];
   logic [15:0] busy_a, busy_b;
   int          checks = 0;
   int          failures = 0;

   // One clock cycle: push expectations for the driven inputs, compare the DUT
   // outputs 1ns later, then advance the model at the rising edge.
   task automatic run_cycle(input string name, input bit chk);
      exp_t e;
      if (chk) begin
         e.name  = name;
         e.a_ro1 = (RegW && RD == R1) ? WriteData : mem_a[R1];
         e.a_ro2 = (RegW && RD == R2) ? WriteData : mem_a[R2];
         e.a_b1  = (RegW && RD == R1) ? 1'b0 : busy_a[R1];
         e.a_b2  = (RegW && RD == R2) ? 1'b0 : busy_a[R2];
         e.b_ro1 = (R1 == 4'd0) ? 16'h0 : mem_b[R1];
         e.b_ro2 = (R2 == 4'd0) ? 16'h0 : mem_b[R2];
         e.b_b1  = busy_b[R1];
         e.b_b2  = busy_b[R2];
         e.a_cnt = 5'($countones(busy_a));
         e.b_cnt = 5'($countones(busy_b));
         sbq.push_back(e);
      end
      #1;
      if (chk) begin
         e = sbq.pop_front();
         checks += 10;
         if (ro1_a !== e.a_ro1) begin failures++; $display("FAIL %s ro1_a got=%h exp=%h", e.name, ro1_a, e.a_ro1); end
         if (ro2_a !== e.a_ro2) begin failures++; $display("FAIL %s ro2_a got=%h exp=%h", e.name, ro2_a, e.a_ro2); end
         if (busy1_a !== e.a_b1) begin failures++; $display("FAIL %s busy1_a got=%b exp=%b", e.name, busy1_a, e.a_b1); end
         if (busy2_a !== e.a_b2) begin failures++; $display("FAIL %s busy2_a got=%b exp=%b", e.name, busy2_a, e.a_b2); end
         if (cnt_a !== e.a_cnt) begin failures++; $display("FAIL %s busy_cnt_a got=%0d exp=%0d", e.name, cnt_a, e.a_cnt); end
         if (ro1_b !== e.b_ro1) begin failures++; $display("FAIL %s ro1_b got=%h exp=%h", e.name, ro1_b, e.b_ro1); end
         if (ro2_b !== e.b_ro2) begin failures++; $display("FAIL %s ro2_b got=%h exp=%h", e.name, ro2_b, e.b_ro2); end
         if (busy1_b !== e.b_b1) begin failures++; $display("FAIL %s busy1_b got=%b exp=%b", e.name, busy1_b, e.b_b1); end
         if (busy2_b !== e.b_b2) begin failures++; $display("FAIL %s busy2_b got=%b exp=%b", e.name, busy2_b, e.b_b2); end
         if (cnt_b !== e.b_cnt) begin failures++; $display("FAIL %s busy_cnt_b got=%0d exp=%0d", e.name, cnt_b, e.b_cnt); end
         $display("cycle %s R1=%0d R2=%0d RO1=%h/%h RO2=%h/%h busy_cnt=%0d/%0d",
                  e.name, R1, R2, ro1_a, ro1_b, ro2_a, ro2_b, cnt_a, cnt_b);
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            mem_a[i] = 16'h0;
            mem_b[i] = 16'h0;
         end
         busy_a = '0;
         busy_b = '0;
      end else begin
         if (RegW) begin
            mem_a[RD]  = WriteData;
            busy_a[RD] = 1'b0;
         end
         if (claim_en) busy_a[claim_addr] = 1'b1;
         if (RegW && RD != 4'd0) begin
            mem_b[RD]  = WriteData;
            busy_b[RD] = 1'b0;
         end
         if (claim_en && claim_addr != 4'd0) busy_b[claim_addr] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; RegW = 1'b0; claim_en = 1'b0;
      RD = 4'd0; claim_addr = 4'd0; WriteData = 16'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      run_cycle("reset", 1'b0);
      run_cycle("reset", 1'b0);
      rst = 1'b0;
      for (int r = 0; r < 16; r++) begin
         R1 = 4'(r);
         R2 = 4'(r + 1);
         run_cycle("reset_read", 1'b1);
      end
   endtask

   task automatic test_fill();
      idle_inputs();
      RegW = 1'b1;
      for (int k = 0; k < 16; k++) begin
         RD = 4'(k); WriteData = 16'(k);
         R1 = 4'(k); R2 = 4'(k + 1);
         run_cycle("fill_write", 1'b1);
      end
      RegW = 1'b0;
      for (int k = 0; k < 16; k += 2) begin
         R1 = 4'(k); R2 = 4'(k + 1);
         run_cycle("fill_read", 1'b1);
      end
   endtask

   task automatic test_bypass();
      idle_inputs();
      RegW = 1'b1; RD = 4'd5; WriteData = 16'h1111; R1 = 4'd0; R2 = 4'd1;
      run_cycle("bypass_setup", 1'b1);
      WriteData = 16'hABCD; R1 = 4'd5; R2 = 4'd5;
      run_cycle("bypass_same_cycle", 1'b1);
      RegW = 1'b0;
      run_cycle("bypass_after_edge", 1'b1);
   endtask

   task automatic test_scoreboard();
      idle_inputs();
      claim_en = 1'b1; claim_addr = 4'd3; R1 = 4'd3; R2 = 4'd7;
      run_cycle("claim3", 1'b1);
      claim_addr = 4'd7;
      run_cycle("claim7", 1'b1);
      claim_en = 1'b0;
      run_cycle("busy_check", 1'b1);
      RegW = 1'b1; RD = 4'd3; WriteData = 16'h3333;
      run_cycle("retire3", 1'b1);
      RegW = 1'b0;
      run_cycle("after_retire3", 1'b1);
      RegW = 1'b1; RD = 4'd12; WriteData = 16'h0C0C; R1 = 4'd12;
      run_cycle("write_not_busy", 1'b1);
      RegW = 1'b0;
      run_cycle("after_write_not_busy", 1'b1);
   endtask

   task automatic test_claim_write();
      idle_inputs();
      claim_en = 1'b1; claim_addr = 4'd9; R1 = 4'd9; R2 = 4'd8;
      run_cycle("claim9", 1'b1);
      RegW = 1'b1; RD = 4'd9; WriteData = 16'h0055;
      run_cycle("claim_write9", 1'b1);
      RegW = 1'b0;
      run_cycle("after_claim_write9", 1'b1);
      run_cycle("reclaim_busy9", 1'b1);
      claim_en = 1'b0;
      run_cycle("after_reclaim9", 1'b1);
   endtask

   task automatic test_zero();
      idle_inputs();
      claim_en = 1'b1; claim_addr = 4'd0; R1 = 4'd0; R2 = 4'd9;
      run_cycle("claim0", 1'b1);
      claim_en = 1'b0;
      RegW = 1'b1; RD = 4'd0; WriteData = 16'h0077; R2 = 4'd0;
      run_cycle("write0", 1'b1);
      RegW = 1'b0;
      run_cycle("read0", 1'b1);
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      claim_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         claim_addr = 4'(1 + 2 * k);
         RegW = 1'b1; RD = 4'(10 + k); WriteData = 16'(16'h0A00 + k);
         R1 = 4'(1 + 2 * k); R2 = 4'd2;
         run_cycle("mid_claim", 1'b1);
      end
      claim_en = 1'b0;
      rst = 1'b1; RegW = 1'b1; RD = 4'd2; WriteData = 16'hFFFF;
      run_cycle("mid_reset", 1'b1);
      rst = 1'b0; RegW = 1'b0;
      for (int r = 0; r < 16; r += 2) begin
         R1 = 4'(r); R2 = 4'(r + 1);
         run_cycle("post_reset_read", 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      idle_inputs();
      for (int n = 0; n < 60; n++) begin
         rst        = ($urandom_range(0, 24) == 0);
         RegW       = 1'($urandom_range(0, 1));
         claim_en   = 1'($urandom_range(0, 1));
         RD         = 4'($urandom_range(0, 15));
         claim_addr = ($urandom_range(0, 3) == 0) ? RD : 4'($urandom_range(0, 15));
         WriteData  = 16'($urandom);
         R1         = ($urandom_range(0, 2) == 0) ? RD : 4'($urandom_range(0, 15));
         R2         = 4'($urandom_range(0, 15));
         run_cycle("random", 1'b1);
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      R1 = 4'd0; R2 = 4'd0;
      busy_a = '0; busy_b = '0;
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 16'h0;
         mem_b[i] = 16'h0;
      end
      @(negedge clk);
      test_reset();
      test_fill();
      test_bypass();
      test_scoreboard();
      test_claim_write();
      test_zero();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised successor to the CPU's 16×16 two-read/one-write register file. Adds a clocked write path, synchronous reset clearing, optional hard-wired zero register, same-cycle write-to-read bypass, and a per-register scoreboard of pending writes so the pipeline can stall on hazards. Sits in the decode stage:

- Read ports feed operand latches.
- Write port is driven by writeback.
- Claim port is driven by issue.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- ZERO_R0, 0, 1 = register 0 reads as zero, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle forwarding of write data to read ports

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  reset, synchronous, active-high
- R1  in  ADDR_W  read address, port 1
- R2  in  ADDR_W  read address, port 2
- RO1  out  DATA_W  read data, port 1 (combinational)
- RO2  out  DATA_W  read data, port 2 (combinational)
- RegW  in  1  write enable
- RD  in  ADDR_W  write address
- WriteData  in  DATA_W  write data
- claim_en  in  1  mark a register as having a pending write
- claim_addr  in  ADDR_W  register being claimed
- busy1  out  1  register R1 has a pending write (combinational)
- busy2  out  1  register R2 has a pending write (combinational)
- busy_cnt  out  ADDR_W+1  number of registers currently busy (registered)

## Operation
- Storage: 2**ADDR_W words of DATA_W bits, plus one busy bit per word.
- Write: at the rising edge with RegW=1, mem[RD] <= WriteData, and busy[RD] is cleared.
- Claim: at the rising edge with claim_en=1, busy[claim_addr] <= 1.
- Simultaneous claim and write to the same address: claim wins. The new producer is issued as the old one retires. Data is written and busy stays 1.
- Claiming an already-busy register leaves it busy; busy_cnt does not change.
- Writing a register that is not busy still updates data; busy_cnt does not change.
- Reads:
  - RO1 = mem[R1], RO2 = mem[R2].
  - With BYPASS=1 and RegW=1 and RD==Rx, ROx = WriteData in the same cycle.
  - Both ports may bypass simultaneously.
- busyx = busy[Rx], except with BYPASS=1 and RegW=1 and RD==Rx, where busyx = 0 because the data is forwarded.
- ZERO_R0=1:
  - Reads of address 0 return 0, overriding bypass.
  - Writes and claims to address 0 are ignored; busy[0] is constant 0.
- busy_cnt: next value = current + (claim sets a new busy bit) − (write clears a set bit that is not re-claimed in the same cycle). It is always equal to the popcount of the busy vector.

## Timing
- Reset (rst=1 at an edge): all mem words 0, all busy bits 0, busy_cnt 0.
  - Reset overrides a write or claim in the same cycle.
  - Reset mid-stream discards all pending claims.
  - RO1/RO2 read 0 from the first cycle after reset, unless bypassed.
- Write latency: data is visible through mem one edge after RegW; it is visible same-cycle only via bypass.
- Claim latency: busy is visible one edge after claim_en.
- Read ports are fully combinational from R1/R2/RD/RegW/WriteData. No read enable.
- Address wrap is not applicable: all 2**ADDR_W addresses are valid.

## Structure
- Package reg_file_pkg: default DATA_W, ADDR_W; a depth constant derived from ADDR_W; zero-register index constant.
- Sub-module reg_scoreboard: holds the busy vector and busy_cnt counter. Inputs are claim/write/rst; outputs are the busy bits for the two read addresses.
- Top module holds the storage array, bypass muxes and ZERO_R0 masking.

## Test plan
- Reset then read: rst=1 for 2 cycles, then R1=0..15, R2=R1+1 -> RO1=RO2=0, busy1=busy2=0, busy_cnt=0.
- Fill and read back:
  - RegW=1, write RD=k with WriteData=k for k=0..15, one per cycle.
  - Then RegW=0 and read pairs (0,1)…(14,15) -> ROx equals the address.
  - With ZERO_R0=1, reads of 0 return 0.
- Bypass:
  - mem[5]=0x1111; in one cycle RegW=1, RD=5, WriteData=0xABCD, R1=R2=5 -> RO1=RO2=0xABCD in that cycle.
  - With BYPASS=0 -> RO1=RO2=0x1111, then 0xABCD after the edge.
- Scoreboard:
  - claim 3 and 7 on successive cycles -> busy_cnt=1, then 2; busy1=1 with R1=3.
  - write RD=3 -> busy_cnt=1 next cycle, and busy1=0 already in the write cycle.
- Simultaneous claim+write to the same address:
  - register 9 busy; RegW=1, RD=9, WriteData=0x55, claim_en=1, claim_addr=9 -> mem[9]=0x55, busy[9]=1, busy_cnt unchanged.
- Reset mid-operation:
  - 4 registers claimed and data written; assert rst in the same cycle as RegW=1, RD=2, WriteData=0xFFFF -> next cycle mem[2]=0, busy_cnt=0, all busy bits 0.
